// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver states, entry layout and constants
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  localparam int MIN_DIV = 4;
  localparam int MAX_DATA_BITS = 9;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_t;
  typedef struct packed {
    logic brk;
    logic ferr;
    logic perr;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO that accepts a push into a full FIFO when a pop happens in the same cycle
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_do_push, w_do_pop;
  assign o_empty = r_wr == r_rd;
  assign o_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + PTR_ONE;
      if (w_do_pop) r_rd <= r_rd + PTR_ONE;
    end
  always_ff @(posedge clk)
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with runtime divisor, majority vote, parity/frame/break flags and receive FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int DIV_W = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     div,
  input  logic                 rx,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 brk,
  output logic                 overrun,
  output logic                 busy
);
  localparam logic [DIV_W-1:0] MIN_D = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);
  rx_state_t r_state, w_state_n;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES:0] r_prime;
  logic r_h1, r_h2;
  logic [DIV_W-1:0] r_div, r_cnt, w_d;
  logic [3:0] r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic r_perr, r_pbit, r_overrun;
  logic w_rxs, w_vote, w_start, w_sample, w_last, w_push, w_pop, w_full, w_empty, w_ferr;
  rx_entry_t w_entry, w_head;
  logic w_unused_head;
  assign w_rxs = r_sync[SYNC_STAGES-1];
  assign w_vote = (w_rxs & r_h1) | (w_rxs & r_h2) | (r_h1 & r_h2);
  assign w_start = r_prime[SYNC_STAGES] & r_h1 & ~w_rxs;
  assign w_d = (div < MIN_D) ? MIN_D : div;
  assign w_sample = (r_state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) && r_cnt == '0;
  assign w_last = r_bit == 4'(DATA_BITS-1);
  assign w_ferr = ~w_vote;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync <= '1;
      r_prime <= '0;
      r_h1 <= 1'b1;
      r_h2 <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
      r_prime <= {r_prime[SYNC_STAGES-1:0], 1'b1};
      r_h1 <= w_rxs;
      r_h2 <= r_h1;
    end
  always_comb begin
    w_state_n = r_state;
    w_push = 1'b0;
    case (r_state)
      ST_IDLE: w_state_n = w_start ? ST_START : ST_IDLE;
      ST_START: if (w_sample) w_state_n = w_vote ? ST_IDLE : ST_DATA;
      ST_DATA: if (w_sample && w_last) w_state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_sample) w_state_n = ST_STOP;
      ST_STOP:
        if (w_sample) begin
          w_push = 1'b1;
          w_state_n = w_ferr ? ST_BREAK_WAIT : ST_IDLE;
        end
      ST_BREAK_WAIT: w_state_n = w_rxs ? ST_IDLE : ST_BREAK_WAIT;
      default: w_state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_div <= MIN_D;
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_perr <= 1'b0;
      r_pbit <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_overrun <= w_push & w_full & ~w_pop;
      if (r_state == ST_IDLE && w_start) begin
        r_div <= w_d;
        r_cnt <= (w_d >> 1) - CNT_ONE;
      end else if (w_sample && r_state != ST_STOP) r_cnt <= r_div - CNT_ONE;
      else if (r_cnt != '0) r_cnt <= r_cnt - CNT_ONE;
      if (r_state == ST_START && w_sample) begin
        r_bit <= '0;
        r_perr <= 1'b0;
        r_pbit <= 1'b0;
      end
      if (r_state == ST_DATA && w_sample) begin
        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
        r_bit <= r_bit + 4'd1;
      end
      if (r_state == ST_PARITY && w_sample) begin
        r_pbit <= w_vote;
        r_perr <= (^r_shift ^ w_vote) != (PARITY == PAR_ODD);
      end
    end
  always_comb begin
    w_entry.data = MAX_DATA_BITS'(r_shift);
    w_entry.perr = r_perr;
    w_entry.ferr = w_ferr;
    w_entry.brk = w_ferr && r_shift == '0 && !r_pbit;
  end
  sync_fifo #(
    .WIDTH($bits(rx_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_din(w_entry),
    .o_dout(w_head),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  assign w_unused_head = ^w_head;
  assign data_valid = ~w_empty;
  assign w_pop = data_valid & data_ready;
  assign data = data_valid ? w_head.data[DATA_BITS-1:0] : '0;
  assign parity_err = data_valid & w_head.perr;
  assign frame_err = data_valid & w_head.ferr;
  assign brk = data_valid & w_head.brk;
  assign overrun = r_overrun;
  assign busy = r_state != ST_IDLE;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of 8N1, 7E1 and 7O1 receivers
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] div = 16'd50;
  logic [2:0] rxv = 3'b111;
  logic [2:0] rdy = 3'b000;
  logic dv8, pe8, fe8, bk8, ov8, bz8;
  logic [7:0] d8;
  logic dve, pee, fee, bke, ove, bze;
  logic [6:0] de;
  logic dvo, peo, feo, bko, ovo, bzo;
  logic [6:0] do7;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rise8 = -1;
  int ov_cnt = 0;
  int t0, ov_base;
  logic dv8_q = 1'b0;
  uart_rx_fifo #(.DATA_BITS(8), .PARITY(0)) u8 (
    .clk(clk), .rst(rst), .div(div), .rx(rxv[0]), .data_valid(dv8), .data_ready(rdy[0]), .data(d8),
    .parity_err(pe8), .frame_err(fe8), .brk(bk8), .overrun(ov8), .busy(bz8));
  uart_rx_fifo #(.DATA_BITS(7), .PARITY(2)) ue (
    .clk(clk), .rst(rst), .div(div), .rx(rxv[1]), .data_valid(dve), .data_ready(rdy[1]), .data(de),
    .parity_err(pee), .frame_err(fee), .brk(bke), .overrun(ove), .busy(bze));
  uart_rx_fifo #(.DATA_BITS(7), .PARITY(1)) uo (
    .clk(clk), .rst(rst), .div(div), .rx(rxv[2]), .data_valid(dvo), .data_ready(rdy[2]), .data(do7),
    .parity_err(peo), .frame_err(feo), .brk(bko), .overrun(ovo), .busy(bzo));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (dv8 && !dv8_q) rise8 = cyc;
    dv8_q = dv8;
    if (ov8) ov_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input int u, input logic v, input int n);
    rxv[u] = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input int u, input logic [9:0] f, input int d);
    for (int i = 0; i < 10; i++) drive(u, f[i], d);
  endtask
  task automatic pop(input int u);
    rdy[u] = 1'b1;
    @(posedge clk);
    #1;
    rdy[u] = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dv", dv8, 0);
    chk("rst_data", d8, 0);
    chk("rst_flags", {pe8, fe8, bk8, ov8, bz8}, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    t0 = cyc;
    send(0, {1'b1, 8'hA5, 1'b0}, 50);
    chk("8n1_rise", rise8 - t0, 478);
    chk("8n1_dv", dv8, 1);
    chk("8n1_data", d8, 8'hA5);
    chk("8n1_flags", {pe8, fe8, bk8, bz8}, 0);
    pop(0);
    chk("8n1_empty", dv8, 0);
    send(1, {1'b1, 1'b0, 7'h41, 1'b0}, 50);
    send(1, {1'b1, 1'b1, 7'h41, 1'b0}, 50);
    drive(1, 1'b1, 20);
    chk("7e1_dv", dve, 1);
    chk("7e1_data", de, 7'h41);
    chk("7e1_good_perr", pee, 0);
    chk("7e1_flags", {fee, bke, ove, bze}, 0);
    pop(1);
    chk("7e1_data2", de, 7'h41);
    chk("7e1_bad_perr", pee, 1);
    pop(1);
    chk("7e1_empty", dve, 0);
    div = 16'd16;
    send(2, {1'b1, 1'b1, 7'h41, 1'b0}, 16);
    send(2, {1'b1, 1'b0, 7'h41, 1'b0}, 16);
    drive(2, 1'b1, 10);
    chk("7o1_data", do7, 7'h41);
    chk("7o1_good_perr", peo, 0);
    chk("7o1_flags", {feo, bko, ovo, bzo}, 0);
    pop(2);
    chk("7o1_bad_perr", peo, 1);
    pop(2);
    chk("7o1_empty", dvo, 0);
    div = 16'd50;
    drive(0, 1'b0, 1);
    drive(0, 1'b1, 60);
    chk("spike_busy", bz8, 0);
    chk("spike_dv", dv8, 0);
    drive(0, 1'b0, 12);
    chk("fstart_busy_mid", bz8, 1);
    drive(0, 1'b1, 60);
    chk("fstart_busy", bz8, 0);
    chk("fstart_dv", dv8, 0);
    drive(0, 1'b0, 1000);
    chk("brk_dv", dv8, 1);
    chk("brk_flags", {bk8, fe8, pe8}, 3'b110);
    chk("brk_data", d8, 0);
    chk("brk_wait_busy", bz8, 1);
    drive(0, 1'b1, 60);
    chk("brk_idle", bz8, 0);
    pop(0);
    chk("brk_single", dv8, 0);
    div = 16'd16;
    ov_base = ov_cnt;
    for (int i = 1; i <= 5; i++) send(0, {1'b1, 8'(i * 17), 1'b0}, 16);
    drive(0, 1'b1, 10);
    chk("ovr_pulse", ov_cnt - ov_base, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_entry", d8, 8'(i * 17));
      pop(0);
    end
    chk("ovr_drained", dv8, 0);
    ov_base = ov_cnt;
    for (int i = 1; i <= 4; i++) send(0, {1'b1, 8'(i * 17), 1'b0}, 16);
    fork
      send(0, {1'b1, 8'h5A, 1'b0}, 16);
      begin
        repeat (154) @(posedge clk);
        #1;
        rdy[0] = 1'b1;
        @(posedge clk);
        #1;
        rdy[0] = 1'b0;
      end
    join
    drive(0, 1'b1, 10);
    chk("pushpop_no_ovr", ov_cnt - ov_base, 0);
    chk("pushpop_head", d8, 8'h22);
    pop(0);
    pop(0);
    pop(0);
    chk("pushpop_tail", d8, 8'h5A);
    pop(0);
    chk("pushpop_drained", dv8, 0);
    div = 16'd50;
    send(0, {1'b1, 8'h77, 1'b0}, 50);
    drive(0, 1'b0, 150);
    chk("prerst_busy", bz8, 1);
    chk("prerst_dv", dv8, 1);
    rst = 1'b1;
    #1;
    chk("midrst_outs", {dv8, pe8, fe8, bk8, ov8, bz8}, 0);
    chk("midrst_data", d8, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1'b0, 100);
    chk("lowrel_busy", bz8, 0);
    chk("lowrel_dv", dv8, 0);
    drive(0, 1'b1, 50);
    send(0, {1'b1, 8'h3C, 1'b0}, 50);
    chk("postrst_dv", dv8, 1);
    chk("postrst_data", d8, 8'h3C);
    chk("postrst_flags", {pe8, fe8, bk8}, 0);
    pop(0);
    chk("postrst_empty", dv8, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
